// File: rtl/lab2_proc_alu_pkg.sv
// Shared definitions for the iterative ALU: function codes, FSM states and
// the helper that separates multi-cycle operations from single-cycle ones.
package lab2_proc_alu_pkg;

  localparam int FnCodeBits = 5;

  typedef enum logic [FnCodeBits-1:0] {
    FN_ADD  = 5'd0,
    FN_SUB  = 5'd1,
    FN_XOR  = 5'd2,
    FN_AND  = 5'd3,
    FN_OR   = 5'd4,
    FN_SRL  = 5'd5,
    FN_SLL  = 5'd6,
    FN_SRA  = 5'd7,
    FN_SLT  = 5'd8,
    FN_SLTU = 5'd9,
    FN_CP0  = 5'd11,
    FN_CP1  = 5'd12,
    FN_MUL  = 5'd16,
    FN_DIV  = 5'd17,
    FN_DIVU = 5'd18,
    FN_REM  = 5'd19,
    FN_REMU = 5'd20
  } fn_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  localparam logic [FnCodeBits-1:0] FnUndefined = 5'd31;

  function automatic logic isIterFn(input logic [FnCodeBits-1:0] fn);
    return (fn == FN_MUL) || (fn == FN_DIV) || (fn == FN_DIVU) ||
           (fn == FN_REM) || (fn == FN_REMU);
  endfunction

endpackage

// File: rtl/lab2_proc_IterMulDivCore.sv
// Bit-serial multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle, with the final step's result presented combinationally.
module lab2_proc_IterMulDivCore
  import lab2_proc_alu_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [FnCodeBits-1:0] fn_i,
  input  logic [p_nbits-1:0]    in0_i,
  input  logic [p_nbits-1:0]    in1_i,
  output logic                  last_o,
  output logic [p_nbits-1:0]    result_o
);

  localparam int CntW = $clog2(p_nbits);
  localparam logic [CntW-1:0] LastCnt = CntW'(p_nbits - 1);

  // acc holds product or partial remainder, opA the multiplicand or divisor,
  // opB the multiplier or the dividend that turns into the quotient.
  logic                  busy_q;
  logic [CntW-1:0]       cnt_q;
  logic [FnCodeBits-1:0] fn_q;
  logic [p_nbits-1:0]    acc_q, opA_q, opB_q;
  logic                  quotNeg_q, remNeg_q;

  logic [p_nbits-1:0]    acc_d, opA_d, opB_d;
  logic [p_nbits:0]      remShift;
  logic                  fits;

  always_comb begin
    remShift = {acc_q, opB_q[p_nbits-1]};
    fits     = remShift >= {1'b0, opA_q};
    if (fn_q == FN_MUL) begin
      acc_d = opB_q[0] ? acc_q + opA_q : acc_q;
      opA_d = opA_q << 1;
      opB_d = opB_q >> 1;
    end else begin
      acc_d = fits ? remShift[p_nbits-1:0] - opA_q : remShift[p_nbits-1:0];
      opA_d = opA_q;
      opB_d = {opB_q[p_nbits-2:0], fits};
    end
  end

  // A zero divisor naturally leaves an all-ones quotient and |in0| as
  // remainder, so only the quotient sign flip has to be suppressed for it.
  always_comb begin
    result_o = '0;
    case (fn_q)
      FN_MUL:  result_o = acc_d;
      FN_DIV:  result_o = quotNeg_q ? -opB_d : opB_d;
      FN_DIVU: result_o = opB_d;
      FN_REM:  result_o = remNeg_q ? -acc_d : acc_d;
      FN_REMU: result_o = acc_d;
      default: result_o = '0;
    endcase
  end

  assign last_o = busy_q && (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      fn_q      <= '0;
      acc_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      quotNeg_q <= 1'b0;
      remNeg_q  <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      fn_q   <= fn_i;
      acc_q  <= '0;
      if (fn_i == FN_MUL) begin
        opA_q     <= in0_i;
        opB_q     <= in1_i;
        quotNeg_q <= 1'b0;
        remNeg_q  <= 1'b0;
      end else if ((fn_i == FN_DIV) || (fn_i == FN_REM)) begin
        opA_q     <= in1_i[p_nbits-1] ? -in1_i : in1_i;
        opB_q     <= in0_i[p_nbits-1] ? -in0_i : in0_i;
        quotNeg_q <= (in0_i[p_nbits-1] ^ in1_i[p_nbits-1]) && (in1_i != '0);
        remNeg_q  <= in0_i[p_nbits-1];
      end else begin
        opA_q     <= in1_i;
        opB_q     <= in0_i;
        quotNeg_q <= 1'b0;
        remNeg_q  <= 1'b0;
      end
    end else if (busy_q) begin
      acc_q <= acc_d;
      opA_q <= opA_d;
      opB_q <= opB_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/lab2_proc_proc_iter_alu.sv
// Iterative ALU top: handshake FSM, single-cycle operations and comparison
// flags, with multiply/divide delegated to the bit-serial core.
module lab2_proc_proc_iter_alu
  import lab2_proc_alu_pkg::*;
#(
  parameter int p_nbits    = 32,
  parameter int p_fn_nbits = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic [p_nbits-1:0]    req_in0,
  input  logic [p_nbits-1:0]    req_in1,
  input  logic [p_fn_nbits-1:0] req_fn,
  output logic                  resp_val,
  input  logic                  resp_rdy,
  output logic [p_nbits-1:0]    resp_out,
  output logic                  resp_eq,
  output logic                  resp_lt,
  output logic                  resp_ltu
);

  localparam int ShW = $clog2(p_nbits);

  state_e             state_q;
  logic               req_rdy_q, resp_val_q;
  logic [p_nbits-1:0] resp_out_q;
  logic               eq_q, lt_q, ltu_q;

  logic [FnCodeBits-1:0] fnCode;
  logic [ShW-1:0]        shamt;
  logic [p_nbits-1:0]    aluOut;
  logic                  accept, iterOp;
  logic                  coreLast;
  logic [p_nbits-1:0]    coreResult;

  // Codes with any bit set above the five defined ones fall into "undefined".
  assign fnCode = ((req_fn >> FnCodeBits) == '0) ? req_fn[FnCodeBits-1:0] : FnUndefined;
  assign shamt  = req_in1[ShW-1:0];
  assign accept = req_val && req_rdy_q;
  assign iterOp = isIterFn(fnCode);

  always_comb begin
    aluOut = '0;
    case (fnCode)
      FN_ADD:  aluOut = req_in0 + req_in1;
      FN_SUB:  aluOut = req_in0 - req_in1;
      FN_XOR:  aluOut = req_in0 ^ req_in1;
      FN_AND:  aluOut = req_in0 & req_in1;
      FN_OR:   aluOut = req_in0 | req_in1;
      FN_SRL:  aluOut = req_in0 >> shamt;
      FN_SLL:  aluOut = req_in0 << shamt;
      FN_SRA:  aluOut = $signed(req_in0) >>> shamt;
      FN_SLT:  aluOut = {{(p_nbits-1){1'b0}}, $signed(req_in0) < $signed(req_in1)};
      FN_SLTU: aluOut = {{(p_nbits-1){1'b0}}, req_in0 < req_in1};
      FN_CP0:  aluOut = req_in0;
      FN_CP1:  aluOut = req_in1;
      default: aluOut = '0;
    endcase
  end

  lab2_proc_IterMulDivCore #(
    .p_nbits (p_nbits)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept && iterOp),
    .fn_i     (fnCode),
    .in0_i    (req_in0),
    .in1_i    (req_in1),
    .last_o   (coreLast),
    .result_o (coreResult)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
      resp_out_q <= '0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      ltu_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_rdy_q <= 1'b0;
            eq_q      <= (req_in0 == req_in1);
            lt_q      <= ($signed(req_in0) < $signed(req_in1));
            ltu_q     <= (req_in0 < req_in1);
            if (iterOp) begin
              state_q <= ST_CALC;
            end else begin
              state_q    <= ST_DONE;
              resp_val_q <= 1'b1;
              resp_out_q <= aluOut;
            end
          end
        end
        ST_CALC: begin
          if (coreLast) begin
            state_q    <= ST_DONE;
            resp_val_q <= 1'b1;
            resp_out_q <= coreResult;
          end
        end
        ST_DONE: begin
          if (resp_val_q && resp_rdy) begin
            state_q    <= ST_IDLE;
            resp_val_q <= 1'b0;
            req_rdy_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_rdy  = req_rdy_q;
  assign resp_val = resp_val_q;
  assign resp_out = resp_out_q;
  assign resp_eq  = eq_q;
  assign resp_lt  = lt_q;
  assign resp_ltu = ltu_q;

endmodule
